// File: rtl/seq_word_serdes.sv
// Shifts W-bit words MSB-first into a bit-serial detector and reassembles its per-bit output; W+1 cycle latency.
// Backpressure: a full, unread output register stalls the final bit; in_ready rises only at word boundaries.
module seq_word_serdes #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         det_in,
    output logic [W-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int KW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-2:0]  asm_q, asm_d;
    logic [W-1:0]  asm_w;
    logic [W-1:0]  out_word_q, out_word_d;
    logic          out_valid_q, out_valid_d;

    logic          final_bit;
    logic          launch_final;
    logic          advance;
    logic          load;

    // Detector output for the bit on ser_out joins the partial result as its LSB.
    assign asm_w        = {asm_q, det_in};
    assign final_bit    = ((state_q == S_SHIFT) && (k_q == '0)) || (state_q == S_STALL);
    assign launch_final = final_bit && (!out_valid_q || out_ready);
    assign advance      = (state_q == S_SHIFT) && (k_q != '0);
    assign load         = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (k_q == '0) begin
                    if (!launch_final) state_d = S_STALL;
                    else               state_d = load ? S_SHIFT : S_IDLE;
                end
            end
            S_STALL: begin
                if (launch_final) state_d = load ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ser_valid = advance || launch_final;
        in_ready  = (state_q == S_IDLE) || launch_final;
        ser_out   = shreg_q[W-1];
        out_word  = out_word_q;
        out_valid = out_valid_q;
    end

    // Datapath next-state; the final bit is not shifted so ser_out holds through idle gaps.
    always_comb begin
        k_d         = k_q;
        shreg_d     = shreg_q;
        asm_d       = asm_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            k_d     = k_q - KW'(1);
            shreg_d = {shreg_q[W-2:0], 1'b0};
            asm_d   = asm_w[W-2:0];
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (launch_final) begin
            out_word_d  = asm_w;
            out_valid_d = 1'b1;
        end
        if (load) begin
            shreg_d = in_word;
            k_d     = KW'(W - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            shreg_q     <= '0;
            asm_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            k_q         <= k_d;
            shreg_q     <= shreg_d;
            asm_q       <= asm_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_word_serdes.sv
// Bench for seq_word_serdes: a "1011" overlapping Mealy detector stub (or echo stub) on the serial side,
// with a word-level reference model computing each result from the concatenated bit stream since reset.
module tb_seq_word_serdes;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in_word;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         det_in;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         out_ready;

    seq_word_serdes #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .det_in    (det_in),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Detector stub: remembers the last three accepted bits, advances only when enabled.
    bit       echo = 1'b1;
    logic [2:0] hist;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hist <= 3'b000;
        else if (ser_valid) hist <= {hist[1:0], ser_out};
    end
    assign det_in = echo ? ser_out : ({hist, ser_out} == 4'b1011);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    bit           exp_bits[$];
    logic [W-1:0] exp_words[$];
    logic [2:0]   mh = 3'b000;
    logic [W-1:0] m_r;
    logic         m_b;
    int           cyc = 0;
    int           sv_cnt = 0;
    int           sv_first = -1;
    int           sv_last = 0;
    int           n_res = 0;
    logic [W-1:0] last_dut_word = '0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_word = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_bits.delete();
            exp_words.delete();
            mh        = 3'b000;
            prev_hold = 1'b0;
        end else begin
            if (ser_valid) begin
                sv_cnt++;
                if (sv_first < 0) sv_first = cyc;
                sv_last = cyc;
                chk("ser_bit_pending", 32'(exp_bits.size() != 0), 32'd1);
                if (exp_bits.size() != 0) chk("ser_out", 32'(ser_out), 32'(exp_bits.pop_front()));
            end
            if (prev_hold) begin
                chk("out_valid_held", 32'(out_valid), 32'd1);
                chk("out_word_held", 32'(out_word), 32'(prev_word));
            end
            if (out_valid && out_ready) begin
                chk("result_pending", 32'(exp_words.size() != 0), 32'd1);
                if (exp_words.size() != 0) begin
                    n_res++;
                    last_dut_word = out_word;
                    chk("out_word", 32'(out_word), 32'(exp_words.pop_front()));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = out_word;
            if (in_valid && in_ready) begin
                for (int i = W - 1; i >= 0; i--) begin
                    m_b = in_word[i];
                    exp_bits.push_back(m_b);
                    m_r[i] = echo ? m_b : ({mh, m_b} == 4'b1011);
                    mh = {mh[1:0], m_b};
                end
                exp_words.push_back(m_r);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(in_valid && in_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(in_valid && in_ready), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_words.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_words.size()), 32'd0);
    endtask

    logic [W-1:0] wa, w1, w2, exp2;
    int           res0;

    initial begin
        in_word   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_word   = W'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            chk("rst_ser_valid", 32'(ser_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_word", 32'(out_word), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_ser_out", 32'(ser_out), 32'd0);
            #4;
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_word   = '0;

        // Single word through the echo stub
        step();
        wa       = 8'hA5;
        in_word  = wa;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            chk("echo_ser_valid", 32'(ser_valid), 32'd1);
            chk("echo_ser_out", 32'(ser_out), 32'(wa[W-c]));
        end
        @(negedge clk);
        chk("echo_out_valid", 32'(out_valid), 32'd1);
        chk("echo_out_word", 32'(out_word), 32'(wa));

        // Continuous stream through the real detector
        echo = 1'b0;
        step();
        sv_cnt   = 0;
        sv_first = -1;
        res0     = n_res;
        for (int i = 0; i < 25; i++) begin
            in_word  = W'(i);
            in_valid = 1'b1;
            wait_accept("stream_accept");
            step();
        end
        in_valid = 1'b0;
        drain("stream_drain");
        chk("stream_ser_valid_cycles", 32'(sv_cnt), 32'd200);
        chk("stream_ser_valid_span", 32'(sv_last - sv_first + 1), 32'd200);
        chk("stream_results", 32'(n_res - res0), 32'd25);

        // Backpressure: hold the first result unread, second word stalls on its last bit
        step();
        w1        = W'($urandom);
        w2        = W'($urandom);
        exp2      = '0;
        in_word   = w1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_accept("bp_accept1");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_word   = w2;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 15) begin
                chk("bp_ser_valid_run", 32'(ser_valid), 32'd1);
            end else begin
                chk("bp_stall_ser_valid", 32'(ser_valid), 32'd0);
                chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
                chk("bp_stall_ser_out", 32'(ser_out), 32'(w2[0]));
                if (c == 16) begin
                    chk("bp_pending_results", 32'(exp_words.size()), 32'd2);
                    if (exp_words.size() == 2) exp2 = exp_words[1];
                end
                if (exp_words.size() != 0) chk("bp_stall_out_word", 32'(out_word), 32'(exp_words[0]));
            end
            if (c == 8) begin
                chk("bp_accept2", 32'(in_valid && in_ready), 32'd1);
                step();
                in_valid = 1'b0;
            end
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ser_valid", 32'(ser_valid), 32'd1);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_result_valid", 32'(out_valid), 32'd1);
        chk("bp_result_word", 32'(out_word), 32'(exp2));
        drain("bp_drain");

        // Reset in the middle of a word while a result is still held
        step();
        out_ready = 1'b0;
        in_word   = 8'h3C;
        in_valid  = 1'b1;
        wait_accept("mid_accept_a");
        step();
        in_valid = 1'b0;
        repeat (W + 1) @(negedge clk);
        chk("mid_pre_out_valid", 32'(out_valid), 32'd1);
        step();
        in_word  = 8'hFF;
        in_valid = 1'b1;
        wait_accept("mid_accept_ff");
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("mid_ser_valid", 32'(ser_valid), 32'd0);
        chk("mid_ser_out", 32'(ser_out), 32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_word", 32'(out_word), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        res0      = n_res;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_result", 32'(out_valid), 32'd0);
        end
        step();
        in_word  = 8'h0F;
        in_valid = 1'b1;
        wait_accept("mid_accept_0f");
        step();
        in_valid = 1'b0;
        drain("mid_drain");
        chk("mid_fresh_results", 32'(n_res - res0), 32'd1);

        // Upstream gap: "101" ends one word, "1" starts the next, match must survive the gap
        step();
        in_word  = 8'h05;
        in_valid = 1'b1;
        wait_accept("gap_accept_a");
        step();
        in_valid = 1'b0;
        repeat (W) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("gap_ser_valid", 32'(ser_valid), 32'd0);
            chk("gap_ser_out", 32'(ser_out), 32'd1);
        end
        step();
        in_word  = 8'hC0;
        in_valid = 1'b1;
        wait_accept("gap_accept_b");
        step();
        in_valid = 1'b0;
        drain("gap_drain");
        chk("gap_cross_match", 32'(last_dut_word), 32'h80);

        // Random traffic with random upstream gaps and downstream backpressure
        for (int i = 0; i < 400; i++) begin
            step();
            in_word   = W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
